// File: rtl/inputport_mc.sv
// inputport_mc: multi-channel clocked input port.
// Each channel takes a 4-phase bundled-data handshake (req/ack_ip + data),
// synchronises req, buffers words in a per-channel FIFO and holds ack_ip low
// while that FIFO is full. The FIFOs are merged by a round-robin arbiter onto a
// single valid/ready stream. Once a word is offered and stalled, the offering
// channel is locked so dout/dch stay stable until the transfer.
// Optional feature: define INPUTPORT_STALL_CNT_EN to build the saturating
// backpressure counter on stall_cnt; otherwise stall_cnt is tied to zero.
module inputport_mc #(
  parameter  int CHANNELS    = 2,
  parameter  int DATA_W      = 8,
  parameter  int DEPTH       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk_inputport,
  input  logic                         rstn,
  input  logic [CHANNELS-1:0]          req,
  input  logic [CHANNELS*DATA_W-1:0]   data,
  output logic [CHANNELS-1:0]          ack_ip,
  output logic                         valid,
  input  logic                         ready,
  output logic [DATA_W-1:0]            dout,
  output logic [CW-1:0]                dch,
  output logic [15:0]                  stall_cnt
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CH_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);

  // Synchroniser chains, acknowledge flags and FIFO storage/pointers.
  logic [CHANNELS-1:0][SYNC_STAGES-1:0]   sync_q;
  logic [CHANNELS-1:0]                    ack_q;
  logic [CHANNELS-1:0][AW:0]              wptr_q;
  logic [CHANNELS-1:0][AW:0]              rptr_q;
  logic [CHANNELS-1:0][DEPTH-1:0][DATA_W-1:0] mem_q;

  // Arbiter state: grant pointer and stall lock.
  logic [CW-1:0] g_q, g_d;
  logic          lock_q, lock_d;
  logic [CW-1:0] lock_ch_q, lock_ch_d;

  // Per-channel status and control.
  logic [CHANNELS-1:0] rs_s;
  logic [CHANNELS-1:0] full_s;
  logic [CHANNELS-1:0] empty_s;
  logic [CHANNELS-1:0] cap_s;
  logic [CHANNELS-1:0] pop_s;

  logic          valid_s;
  logic          xfer_s;
  logic [CW-1:0] sel_s;

  // Per-channel synchronised request, FIFO status and capture decision.
  // Full is judged on the registered pointers, i.e. before any same-cycle pop.
  always_comb begin
    rs_s    = '0;
    full_s  = '0;
    empty_s = '0;
    cap_s   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rs_s[i]    = sync_q[i][SYNC_STAGES-1];
      empty_s[i] = (wptr_q[i] == rptr_q[i]);
      full_s[i]  = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                   (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
      cap_s[i]   = rs_s[i] & ~ack_q[i] & ~full_s[i];
    end
  end

  // Channel selection: the locked channel if any, else the first non-empty
  // FIFO scanning upward from the grant pointer with wrap-around.
  always_comb begin : arb_sel
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    sel_s   = '0;
    valid_s = |(~empty_s);
    if (lock_q) begin
      sel_s = lock_ch_q;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = (int'(g_q) + k) % CHANNELS;
        if (!found && !empty_s[idx]) begin
          sel_s = CW'(idx);
          found = 1'b1;
        end else begin
          found = found;
        end
      end
    end
  end

  // Transfer handshake and per-channel pop strobes.
  always_comb begin
    xfer_s = valid_s & ready;
    pop_s  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop_s[i] = xfer_s && (sel_s == CW'(i));
    end
  end

  // Next grant pointer and lock: lock while stalled, release and advance on transfer.
  always_comb begin
    g_d       = g_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer_s) begin
      g_d       = (sel_s == CH_LAST) ? '0 : (sel_s + CH_ONE);
      lock_d    = 1'b0;
      lock_ch_d = '0;
    end else if (valid_s) begin
      lock_d    = 1'b1;
      lock_ch_d = sel_s;
    end else begin
      lock_d    = 1'b0;
      lock_ch_d = '0;
    end
  end

  // Synchronisers, acknowledges and FIFO pointers; reset drops ack and empties FIFOs.
  always_ff @(posedge clk_inputport or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      ack_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], req[i]};
        if (cap_s[i]) begin
          ack_q[i] <= 1'b1;
        end else if (!rs_s[i]) begin
          ack_q[i] <= 1'b0;
        end else begin
          ack_q[i] <= ack_q[i];
        end
        if (cap_s[i]) begin
          wptr_q[i] <= wptr_q[i] + PTR_ONE;
        end else begin
          wptr_q[i] <= wptr_q[i];
        end
        if (pop_s[i]) begin
          rptr_q[i] <= rptr_q[i] + PTR_ONE;
        end else begin
          rptr_q[i] <= rptr_q[i];
        end
      end
    end
  end

  // FIFO storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_inputport) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (cap_s[i]) begin
        mem_q[i][wptr_q[i][AW-1:0]] <= data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk_inputport or negedge rstn) begin
    if (!rstn) begin
      g_q       <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      g_q       <= g_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  assign ack_ip = ack_q;
  assign valid  = valid_s;
  assign dout   = valid_s ? mem_q[sel_s][rptr_q[sel_s][AW-1:0]] : {DATA_W{1'b0}};
  assign dch    = valid_s ? sel_s : {CW{1'b0}};

`ifdef INPUTPORT_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        stall_ev_s;

  // A stall is a sender held off by a full FIFO, or an output word not taken.
  assign stall_ev_s = (|(rs_s & ~ack_q & full_s)) | (valid_s & ~ready);

  // Saturating backpressure counter, cleared only by reset.
  always_ff @(posedge clk_inputport or negedge rstn) begin
    if (!rstn) begin
      stall_q <= 16'h0000;
    end else if (stall_ev_s && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/inputport_mc.md
# inputport_mc

Parametrised multi-channel successor to the single-channel clocked input port. It accepts CHANNELS independent asynchronous 4-phase bundled-data handshakes (req/ack_ip plus data) into the clk_inputport domain. Each channel has a synchroniser and a DEPTH-entry FIFO. Channels are merged through a round-robin arbiter onto one valid/ready stream consumed by the bridge core. Unlike the single-channel port, it carries data, buffers multiple words, applies backpressure via a delayed ack, and arbitrates between channels.

## Interface

Parameters:
- CHANNELS, 2: number of input channels (1..8).
- DATA_W, 8: data bits per channel.
- DEPTH, 4: FIFO entries per channel (power of two, ≥2).
- SYNC_STAGES, 2: synchroniser flops on each req (≥2).

Ports:
- clk_inputport input 1: the single clock; all state is on its rising edge.
- rstn input 1: reset, asynchronous and active-low.
- req input CHANNELS: per-channel 4-phase request, asynchronous to clk_inputport.
- data input CHANNELS*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W]; stable while req[i] is high.
- ack_ip output CHANNELS: per-channel acknowledge, registered.
- valid output 1: dout/dch hold a word.
- ready input 1: consumer accepts the word when valid && ready.
- dout output DATA_W: head word of the granted channel.
- dch output $clog2(CHANNELS) (minimum 1): index of the granted channel.
- stall_cnt output 16: saturating count of backpressure cycles (see Configuration).

## Operation

Per channel i:
- req[i] passes through SYNC_STAGES flops, giving rs[i].
- Capture condition: rs[i]=1, ack_ip[i]=0 and FIFO i not full. On capture, data slice i is written to FIFO i and ack_ip[i] is set to 1 at the same edge.
- ack_ip[i] clears on the first edge where rs[i]=0. One word is written per 4-phase cycle.
- Backpressure: while FIFO i is full, the capture condition is false and ack_ip[i] stays low.
- FIFO full is evaluated before the same-cycle read. A read and a capture in the same cycle on a full FIFO do not combine; the capture happens on the next edge.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full means the MSBs differ and the lower bits are equal. Empty means the pointers are equal.

Arbiter:
- State: grant pointer g in 0..CHANNELS-1, reset to 0.
- Selection is combinational: starting at g, the first non-empty FIFO in ascending modulo order.
- valid = (any FIFO non-empty). dout is that FIFO's head and dch is its index. When valid=0, dout=0 and dch=0.
- Lock: when valid && !ready, the selected channel is registered as locked. dout and dch must not change until transfer, even if a lower-priority-order channel fills.
- Transfer (valid && ready): pop the selected FIFO and set g = selected+1 mod CHANNELS.
- CHANNELS=1: g is constant 0.

## Timing

- Reset values: ack_ip=0, valid=0, dout=0, dch=0, stall_cnt=0. Sync flops are 0, FIFOs are empty, g=0 and lock is cleared.
- rstn assertion mid-handshake drops ack_ip asynchronously and discards buffered words. The sender must return req to 0 before starting a new cycle.
- The req rising edge must be stable at least SYNC_STAGES edges before it is seen.
- ack_ip rises SYNC_STAGES+1 edges after req rises, when the FIFO has space.
- ack_ip falls SYNC_STAGES+1 edges after req falls.
- Capture to valid: valid is high in the cycle after the capturing edge, provided no other channel is already locked.
- Throughput: one word per clock on the output side. Per channel, at most one word per 2*(SYNC_STAGES+1) clocks.
- Simultaneous captures on all channels are all accepted in the same edge.

## Configuration

- INPUTPORT_STALL_CNT_EN defined:
  - stall_cnt increments by 1 on every edge where any channel has rs=1, ack_ip=0 and a full FIFO, or where valid && !ready.
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined: stall_cnt is tied to 0 and no counter logic is generated.

## Test plan

- Reset and single word (CHANNELS=2, DATA_W=8, SYNC_STAGES=2), ready=1: channel 0 sends 8'hA5.
  - ack_ip[0] rises 3 edges after req.
  - valid is high for 1 cycle with dout=8'hA5, dch=0.
  - ack_ip[0] falls 3 edges after req falls.
- Fill to DEPTH=4 with ready=0: channel 1 sends 8'h01..8'h05.
  - Four acks complete; the fifth ack stays low.
  - Raise ready: outputs 01,02,03,04, then the fifth ack completes and 05 is output.
- Round robin: both FIFOs hold 2 words and ready=1.
  - dch sequence is 0,1,0,1 with the words in FIFO order per channel.
- Lock under stall: ready=0, channel 1 word pending with dch=1, then channel 0 fills.
  - dch stays 1 until ready=1.
  - The next transfer is from channel 0.
- Reset mid-operation: assert rstn=0 while ack_ip[0]=1 and 2 words are buffered.
  - ack_ip, valid, dout and dch read 0 immediately.
  - After release with req low, the port is empty.
- Macro: with INPUTPORT_STALL_CNT_EN and ready held 0 for 10 cycles with valid=1, stall_cnt=10. Without the macro, stall_cnt=0.
